keypad_multitap_ctrl: RTL

- Sequences the 4x3 matrix keypad shared by the host and player consoles.
- Drives one-hot column strobes and samples the 4 row lines.
- Debounces presses and turns phone-style multi-tap presses into committed ASCII letters plus submit/clear events.
- Sits between the keypad pins and the game logic that builds and guesses the word; one instance per console.

---
 rtl/hangman_pkg.sv | 47 ++++
 rtl/keypad_scanner.sv | 149 ++++++++++++++
 rtl/keypad_multitap_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared keypad definitions: special key indices, letter-group tables and the
// debounce state encoding used by the keypad scanner.
package hangman_pkg;

  localparam logic [3:0] KEY_NONE          = 4'd0;
  localparam logic [3:0] KEY_SUBMIT_LETTER = 4'd9;
  localparam logic [3:0] KEY_CLEAR         = 4'd10;
  localparam logic [3:0] KEY_SUBMIT_WORD   = 4'd11;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_CHK,
    DB_HELD,
    DB_REL_CHK
  } db_state_e;

  function automatic logic is_group(input logic [3:0] k);
    return (k >= 4'd1) && (k <= 4'd8);
  endfunction

  function automatic logic [7:0] grp_first(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h41;  // A
      4'd2:    return 8'h44;  // D
      4'd3:    return 8'h47;  // G
      4'd4:    return 8'h4A;  // J
      4'd5:    return 8'h4D;  // M
      4'd6:    return 8'h50;  // P
      4'd7:    return 8'h54;  // T
      4'd8:    return 8'h57;  // W
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] grp_size(input logic [3:0] k);
    case (k)
      4'd6, 4'd8:                               return 8'd4;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7:       return 8'd3;
      default:                                  return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] grp_last(input logic [3:0] k);
    return grp_first(k) + grp_size(k) - 8'd1;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column strobing, per-frame classification (empty/single/multi) and the
// press/release debounce FSM; emits one key_valid pulse per debounced press.
module keypad_scanner
  import hangman_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic          last_dwell, frame_end;

  assign last_dwell = (dwell == DW'(SCAN_CYCLES - 1));
  assign frame_end  = last_dwell && (col == 2'd2);
  assign cols       = 3'(3'b001 << col);

  // Current column sample
  logic       smp_any, smp_multi;
  logic [1:0] smp_row;
  logic [3:0] smp_key;

  always_comb begin
    smp_row = 2'd0;
    case (rows)
      4'b1000: smp_row = 2'd0;
      4'b0100: smp_row = 2'd1;
      4'b0010: smp_row = 2'd2;
      4'b0001: smp_row = 2'd3;
      default: smp_row = 2'd0;
    endcase
  end

  assign smp_any   = |rows;
  assign smp_multi = (rows & (rows - 4'd1)) != 4'd0;
  assign smp_key   = {2'b00, smp_row} * 4'd3 + {2'b00, col};

  // Frame so far, combined with the current sample
  logic       acc_single, acc_multi;
  logic [3:0] acc_key;
  logic       f_single, f_multi, f_empty;
  logic [3:0] f_key;

  assign f_multi  = acc_multi | smp_multi | (acc_single & smp_any);
  assign f_single = !f_multi && (acc_single || smp_any);
  assign f_empty  = !f_multi && !f_single;
  assign f_key    = acc_single ? acc_key : smp_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= 2'd0;
      dwell      <= '0;
      acc_single <= 1'b0;
      acc_multi  <= 1'b0;
      acc_key    <= 4'd0;
    end else if (last_dwell) begin
      dwell <= '0;
      col   <= (col == 2'd2) ? 2'd0 : col + 2'd1;
      if (col == 2'd2) begin
        acc_single <= 1'b0;
        acc_multi  <= 1'b0;
      end else begin
        acc_single <= f_single;
        acc_multi  <= f_multi;
        acc_key    <= f_key;
      end
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  db_state_e     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    kq, kq_n;
  logic          fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= DB_IDLE;
      cnt       <= '0;
      kq        <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      kq        <= kq_n;
      key_valid <= fire;
      if (fire) key_code <= kq_n;
    end
  end

  // Debounce decisions are taken only when a full frame has been seen.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    kq_n  = kq;
    fire  = 1'b0;
    if (frame_end) begin
      case (st)
        DB_IDLE: if (f_single) begin
          kq_n  = f_key;
          cnt_n = CW'(1);
          if (DEBOUNCE_FRAMES == 1) begin
            fire = 1'b1;
            st_n = DB_HELD;
          end else begin
            st_n = DB_PRESS_CHK;
          end
        end
        DB_PRESS_CHK: if (f_single && f_key == kq) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == CW'(DEBOUNCE_FRAMES)) begin
            fire = 1'b1;
            st_n = DB_HELD;
          end
        end else if (f_single) begin
          kq_n  = f_key;
          cnt_n = CW'(1);
        end else begin
          st_n = DB_IDLE;
        end
        DB_HELD: if (f_empty) begin
          cnt_n = CW'(1);
          if (DEBOUNCE_FRAMES == 1) st_n = DB_IDLE;
          else                      st_n = DB_REL_CHK;
        end
        DB_REL_CHK: if (f_empty) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == CW'(DEBOUNCE_FRAMES)) st_n = DB_IDLE;
        end else begin
          st_n = DB_HELD;
        end
        default: st_n = DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_multitap_ctrl.sv
// Keypad front end for one console: scanner plus phone-style multi-tap letter
// entry with commit, clear and word-submit events.
module keypad_multitap_ctrl
  import hangman_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int TAP_TIMEOUT     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [7:0] cur_letter,
  output logic       cur_valid,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       word_submit,
  output logic       clear
);

  localparam int TW = $clog2(TAP_TIMEOUT + 1);

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  logic [TW-1:0] tap_tmr;
  logic [3:0]    last_grp;

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_tmr      <= '0;
      last_grp     <= 4'd0;
      cur_letter   <= 8'd0;
      cur_valid    <= 1'b0;
      letter       <= 8'd0;
      letter_valid <= 1'b0;
      word_submit  <= 1'b0;
      clear        <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      word_submit  <= 1'b0;
      clear        <= 1'b0;
      if (tap_tmr != '0) tap_tmr <= tap_tmr - TW'(1);
      if (key_valid) begin
        if (is_group(key_code)) begin
          tap_tmr   <= TW'(TAP_TIMEOUT);
          last_grp  <= key_code;
          cur_valid <= 1'b1;
          // Repeat tap inside the window cycles through the group letters.
          if (key_code == last_grp && tap_tmr != '0)
            cur_letter <= (cur_letter == grp_last(key_code)) ? grp_first(key_code)
                                                              : cur_letter + 8'd1;
          else
            cur_letter <= grp_first(key_code);
        end else if (key_code == KEY_SUBMIT_LETTER) begin
          if (cur_valid) begin
            letter       <= cur_letter;
            letter_valid <= 1'b1;
            cur_valid    <= 1'b0;
            tap_tmr      <= '0;
          end
        end else if (key_code == KEY_CLEAR) begin
          clear     <= 1'b1;
          cur_valid <= 1'b0;
          tap_tmr   <= '0;
        end else if (key_code == KEY_SUBMIT_WORD) begin
          word_submit <= 1'b1;
          cur_valid   <= 1'b0;
        end
      end
    end
  end

endmodule
